uart_rx: RTL



---
 rtl/uart_rx_if.sv | 39 +++
 rtl/uart_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// ---------------------------------------------------------------------------
// uart_rx_if
//
// Purpose: bundles the serial line and the byte-delivery signals that run
// between the board RX pin, the uart_rx receiver and the downstream
// command/protocol controller.
//
// Signals:
//   rx          raw serial line, idle high, asynchronous to the system clock
//   dataIn      [7:0] last correctly framed byte, LSB received first
//   byteReady   one-cycle strobe, dataIn has just been updated
//   frameError  one-cycle strobe, the stop bit was sampled low
//
// Modports:
//   master  the receiver: reads rx, drives the byte and the strobes
//   slave   the line source / byte consumer side
// ---------------------------------------------------------------------------
interface uart_rx_if;

    logic       rx;
    logic [7:0] dataIn;
    logic       byteReady;
    logic       frameError;

    modport master (
        input  rx,
        output dataIn,
        output byteReady,
        output frameError
    );

    modport slave (
        output rx,
        input  dataIn,
        input  byteReady,
        input  frameError
    );

endinterface

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Purpose: 8N1 asynchronous serial receiver. Synchronizes the RX pin,
// rejects short start-bit glitches, samples every bit in the middle of its
// period and checks the stop bit. Each good byte is presented on dataIn with
// a one-cycle byteReady strobe; a low stop bit gives a one-cycle frameError
// strobe instead and the receiver then waits for the line to go idle.
//
// Parameters:
//   CLK_HZ  system clock frequency in Hz
//   BAUD    serial line rate; CLK_HZ/BAUD must be at least 4
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous, active-low reset
//   bus     uart_rx_if.master (rx in; dataIn, byteReady, frameError out)
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLK_HZ = 12_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master bus
);

    // Clocks per bit and clocks to the middle of the start bit.
    localparam int C     = CLK_HZ / BAUD;
    localparam int H     = C / 2;
    localparam int CNT_W = (C > 1) ? $clog2(C) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Fewer than four clocks per bit leaves no room for mid-bit sampling.
    generate
        if (C < 4) begin : gBadRatio
            $error("uart_rx: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic             sync1_q;
    logic             rxs_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       data_q, data_d;
    logic             rdy_q, rdy_d;
    logic             fe_q, fe_d;

    // Two-flop synchronizer on the asynchronous pin. Both stages reset to the
    // idle (high) level so that a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            rxs_q   <= sync1_q;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic. The start bit is re-checked half a bit after the
    // falling edge so short low glitches fall back to IDLE silently; after
    // that every sample lands a full bit period later, i.e. mid-bit. Strobes
    // default low, so each one lasts exactly one cycle, and both strobes lead
    // to a state that cannot issue another strobe on the following cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rdy_d   = 1'b0;
        fe_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    sh_d  = {rxs_q, sh_q[7:1]};
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        data_d  = sh_q;
                        rdy_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A line held low after a bad stop bit is a break, not a stream
            // of zero bytes: wait for it to return high before re-arming.
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.dataIn     = data_q;
    assign bus.byteReady  = rdy_q;
    assign bus.frameError = fe_q;

endmodule
